// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with a two-bit opcode interface, occupancy count, threshold
// flags, a read-data valid strobe and one-cycle reject pulses.
module param_sync_fifo #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    parameter  int AF_THRESH  = 14,
    parameter  int AE_THRESH  = 2,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  ResetN,
    input  logic [1:0]            Opcode,
    input  logic [DATA_WIDTH-1:0] Din,
    output logic [DATA_WIDTH-1:0] Dout,
    output logic                  DoutValid,
    output logic [AW:0]           Count,
    output logic                  FifoFull,
    output logic                  FifoEmpty,
    output logic                  AlmostFull,
    output logic                  AlmostEmpty,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] CNT_AE   = (AW+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [AW:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  wr_req, rd_req;
    logic                  wr_acc, rd_acc;

    assign FifoFull    = (count_q == CNT_FULL);
    assign FifoEmpty   = (count_q == '0);
    assign AlmostFull  = (count_q >= CNT_AF);
    assign AlmostEmpty = (count_q <= CNT_AE);

    // Full and empty are exclusive (DEPTH >= 4), so opcode 11 always moves at
    // most one side when at a boundary and both sides otherwise.
    always_comb begin
        wr_req       = Opcode[0];
        rd_req       = Opcode[1];
        wr_acc       = wr_req & ~FifoFull;
        rd_acc       = rd_req & ~FifoEmpty;

        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = rd_acc;
        overflow_d   = wr_req & FifoFull;
        underflow_d  = rd_req & FifoEmpty;

        if (wr_acc) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + AW'(1);
            dout_d = mem_q[rptr_q];
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; writes are blocked while reset is asserted.
    always_ff @(posedge Clk) begin
        if (ResetN && wr_acc) begin
            mem_q[wptr_q] <= Din;
        end
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign Dout      = dout_q;
    assign DoutValid = dout_valid_q;
    assign Count     = count_q;
    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed table plus corner sequences on a 32x16 FIFO, then biased random
// traffic on it and on an 8x4 instance, each checked against a queue model.
module tb_param_sync_fifo;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic [1:0]  Opcode;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        DoutValid;
    logic [4:0]  Count;
    logic        FifoFull, FifoEmpty, AlmostFull, AlmostEmpty, Overflow, Underflow;

    logic [1:0]  op_s;
    logic [7:0]  din_s;
    logic [7:0]  dout_s;
    logic        dv_s;
    logic [2:0]  count_s;
    logic        full_s, empty_s, af_s, ae_s, ovf_s, udf_s;

    int n_cmp = 0;
    int n_err = 0;

    param_sync_fifo dut (
        .Clk(Clk), .ResetN(ResetN), .Opcode(Opcode), .Din(Din),
        .Dout(Dout), .DoutValid(DoutValid), .Count(Count),
        .FifoFull(FifoFull), .FifoEmpty(FifoEmpty),
        .AlmostFull(AlmostFull), .AlmostEmpty(AlmostEmpty),
        .Overflow(Overflow), .Underflow(Underflow)
    );

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) dut_s (
        .Clk(Clk), .ResetN(ResetN), .Opcode(op_s), .Din(din_s),
        .Dout(dout_s), .DoutValid(dv_s), .Count(count_s),
        .FifoFull(full_s), .FifoEmpty(empty_s),
        .AlmostFull(af_s), .AlmostEmpty(ae_s),
        .Overflow(ovf_s), .Underflow(udf_s)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] din;
        int          cnt;
        logic [31:0] dout;
        logic        dv;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Expected flags are derived from the expected count and the instance's thresholds.
    task automatic chk_main(input string tag, input int cnt, input logic [31:0] dout,
                            input logic dv, input logic ovf, input logic udf);
        chk({tag, " count"}, 64'(Count), 64'(cnt));
        chk({tag, " dout"}, 64'(Dout), 64'(dout));
        chk({tag, " dvalid"}, 64'(DoutValid), 64'(dv));
        chk({tag, " ovf"}, 64'(Overflow), 64'(ovf));
        chk({tag, " udf"}, 64'(Underflow), 64'(udf));
        chk({tag, " full"}, 64'(FifoFull), 64'(cnt == 16));
        chk({tag, " empty"}, 64'(FifoEmpty), 64'(cnt == 0));
        chk({tag, " afull"}, 64'(AlmostFull), 64'(cnt >= 14));
        chk({tag, " aempty"}, 64'(AlmostEmpty), 64'(cnt <= 2));
    endtask

    task automatic chk_small(input string tag, input int cnt, input logic [7:0] dout,
                             input logic dv, input logic ovf, input logic udf);
        chk({tag, " count"}, 64'(count_s), 64'(cnt));
        chk({tag, " dout"}, 64'(dout_s), 64'(dout));
        chk({tag, " dvalid"}, 64'(dv_s), 64'(dv));
        chk({tag, " ovf"}, 64'(ovf_s), 64'(ovf));
        chk({tag, " udf"}, 64'(udf_s), 64'(udf));
        chk({tag, " full"}, 64'(full_s), 64'(cnt == 4));
        chk({tag, " empty"}, 64'(empty_s), 64'(cnt == 0));
        chk({tag, " afull"}, 64'(af_s), 64'(cnt >= 3));
        chk({tag, " aempty"}, 64'(ae_s), 64'(cnt <= 1));
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] din);
        Opcode = op;
        Din    = din;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [1:0] pick_op(input bit write_heavy);
        int r;
        r = $urandom_range(0, 99);
        if (r < 10)                      return 2'b00;
        if (r < (write_heavy ? 60 : 30)) return 2'b01;
        if (r < 80)                      return 2'b10;
        return 2'b11;
    endfunction

    logic [31:0] qm [$];
    logic [7:0]  qs [$];

    initial begin
        logic [31:0] ed;
        logic [31:0] em_dout;
        logic        em_dv, em_ovf, em_udf;
        logic [7:0]  es_dout;
        logic        es_dv, es_ovf, es_udf;
        logic        full, empty, wa, ra;

        vecs[0]  = '{2'b00, 32'h0,        0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b10, 32'h0,        0, 32'h0,        1'b0, 1'b0, 1'b1};
        vecs[2]  = '{2'b10, 32'h0,        0, 32'h0,        1'b0, 1'b0, 1'b1};
        vecs[3]  = '{2'b00, 32'h0,        0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[4]  = '{2'b01, 32'h11,       1, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[5]  = '{2'b01, 32'h22,       2, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[6]  = '{2'b01, 32'h33,       3, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 32'h0,        2, 32'h11,       1'b1, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 32'h44,       2, 32'h22,       1'b1, 1'b0, 1'b0};
        vecs[9]  = '{2'b00, 32'h0,        2, 32'h22,       1'b0, 1'b0, 1'b0};
        vecs[10] = '{2'b10, 32'h0,        1, 32'h33,       1'b1, 1'b0, 1'b0};
        vecs[11] = '{2'b10, 32'h0,        0, 32'h44,       1'b1, 1'b0, 1'b0};
        vecs[12] = '{2'b10, 32'h0,        0, 32'h44,       1'b0, 1'b0, 1'b1};
        vecs[13] = '{2'b11, 32'hA5A5A5A5, 1, 32'h44,       1'b0, 1'b0, 1'b1};
        vecs[14] = '{2'b10, 32'h0,        0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0};

        ResetN = 1'b0;
        Opcode = 2'b00;
        Din    = '0;
        op_s   = 2'b00;
        din_s  = '0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        chk_main("reset", 0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_small("reset_s", 0, 8'h0, 1'b0, 1'b0, 1'b0);
        ResetN = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].op, vecs[i].din);
            chk_main($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout,
                     vecs[i].dv, vecs[i].ovf, vecs[i].udf);
        end
        ed = 32'hA5A5A5A5;

        // Fill to full, reject one write, then opcode 11 on full, then drain.
        for (int i = 0; i < 16; i++) begin
            drive(2'b01, 32'h1000 + 32'(i));
            chk_main($sformatf("fill%0d", i), i + 1, ed, 1'b0, 1'b0, 1'b0);
        end
        drive(2'b01, 32'hDEAD);
        chk_main("wr_full", 16, ed, 1'b0, 1'b1, 1'b0);
        drive(2'b00, 32'h0);
        chk_main("idle_full", 16, ed, 1'b0, 1'b0, 1'b0);
        drive(2'b11, 32'hBEEF);
        ed = 32'h1000;
        chk_main("rw_full", 15, ed, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) begin
            drive(2'b10, 32'h0);
            ed = 32'h1000 + 32'(i);
            chk_main($sformatf("drain%0d", i), 15 - i, ed, 1'b1, 1'b0, 1'b0);
        end
        drive(2'b10, 32'h0);
        chk_main("rd_empty", 0, ed, 1'b0, 1'b0, 1'b1);

        // Steady opcode 11 at occupancy 5, carrying both pointers past the wrap.
        for (int i = 0; i < 5; i++) begin
            drive(2'b01, 32'h2000 + 32'(i));
            chk_main($sformatf("pre%0d", i), i + 1, ed, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            drive(2'b11, 32'h2005 + 32'(i));
            ed = 32'h2000 + 32'(i);
            chk_main($sformatf("rw%0d", i), 5, ed, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(2'b10, 32'h0);
            ed = 32'h2014 + 32'(i);
            chk_main($sformatf("post%0d", i), 4 - i, ed, 1'b1, 1'b0, 1'b0);
        end

        // Reset mid-stream with 5 entries and a write presented on the reset edge.
        for (int i = 0; i < 5; i++) drive(2'b01, 32'h3000 + 32'(i));
        drive(2'b10, 32'h0);
        drive(2'b01, 32'h3005);
        chk_main("pre_rst", 5, 32'h3000, 1'b0, 1'b0, 1'b0);
        ResetN = 1'b0;
        drive(2'b01, 32'h3006);
        chk_main("mid_rst", 0, 32'h0, 1'b0, 1'b0, 1'b0);
        ResetN = 1'b1;
        drive(2'b00, 32'h0);
        chk_main("post_rst", 0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(2'b10, 32'h0);
        chk_main("post_rst_rd", 0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Biased random traffic on both instances against queue models.
        em_dout = '0;
        es_dout = '0;
        for (int i = 0; i < 3000; i++) begin
            bit wh;
            wh     = ((i / 150) % 2) == 0;
            Opcode = pick_op(wh);
            Din    = $urandom;
            op_s   = pick_op(wh);
            din_s  = 8'($urandom);

            full   = qm.size() == 16;
            empty  = qm.size() == 0;
            wa     = Opcode[0] && !full;
            ra     = Opcode[1] && !empty;
            em_ovf = Opcode[0] && full;
            em_udf = Opcode[1] && empty;
            em_dv  = ra;
            if (ra) em_dout = qm.pop_front();
            if (wa) qm.push_back(Din);

            full   = qs.size() == 4;
            empty  = qs.size() == 0;
            wa     = op_s[0] && !full;
            ra     = op_s[1] && !empty;
            es_ovf = op_s[0] && full;
            es_udf = op_s[1] && empty;
            es_dv  = ra;
            if (ra) es_dout = qs.pop_front();
            if (wa) qs.push_back(din_s);

            @(posedge Clk);
            #1;
            chk_main($sformatf("rnd%0d", i), qm.size(), em_dout, em_dv, em_ovf, em_udf);
            chk_small($sformatf("rnds%0d", i), qs.size(), es_dout, es_dv, es_ovf, es_udf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
